// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: fetch FSM states,
// datapath defaults and instruction-field positions used by the decoder side.
package fetch_stage_pkg;

    localparam int          BUS_W        = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          PC_STEP_DEF  = 4;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_e;

    // Instruction word field boundaries
    localparam int FUNTYPE_HI = 31;
    localparam int FUNTYPE_LO = 30;
    localparam int FUNCODE_HI = 29;
    localparam int FUNCODE_LO = 28;
    localparam int RD_HI      = 27;
    localparam int RD_LO      = 24;

    function automatic logic [1:0] instr_funtype(input logic [31:0] instr);
        return instr[FUNTYPE_HI:FUNTYPE_LO];
    endfunction

    function automatic logic [1:0] instr_funcode(input logic [31:0] instr);
        return instr[FUNCODE_HI:FUNCODE_LO];
    endfunction

    function automatic logic [3:0] instr_rd(input logic [31:0] instr);
        return instr[RD_HI:RD_LO];
    endfunction

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry skid register holding a fetched word and its PC while the
// IF/ID output register is stalled by the decoder.
module fetch_skid_reg
    import fetch_stage_pkg::*;
#(
    parameter int BUS = BUS_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           unload,
    input  logic           flush,
    input  logic [31:0]    load_data,
    input  logic [BUS-1:0] load_pc,
    output logic           full,
    output logic [31:0]    data,
    output logic [BUS-1:0] pc
);

    // A load in the same cycle as unload/flush wins: the new word is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
            pc   <= '0;
        end else begin
            if (unload || flush) begin
                full <= 1'b0;
            end
            if (load) begin
                full <= 1'b1;
                data <= load_data;
                pc   <= load_pc;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding memory reads,
// and presents fetched words to the decoder through the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int             BUS      = BUS_W,
    parameter logic [BUS-1:0] RESET_PC = BUS'(RESET_PC_DEF),
    parameter int             PC_STEP  = PC_STEP_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic           imem_req,
    output logic [BUS-1:0] imem_addr,
    input  logic [31:0]    imem_rdata,
    input  logic           imem_valid,
    input  logic           branch_taken,
    input  logic [BUS-1:0] branch_target,
    input  logic           id_ready,
    output logic           if_valid,
    output logic [31:0]    if_instr,
    output logic [BUS-1:0] if_pc,
    output logic [31:0]    fetch_count
);

    localparam logic [BUS-1:0] STEP = BUS'(PC_STEP);

    fetch_state_e   state;
    logic           run;
    logic [BUS-1:0] pc;
    logic [BUS-1:0] pc_seq;
    logic           handoff;
    logic           out_free;
    logic           skid_load;
    logic           skid_unload;
    logic           skid_flush;
    logic           skid_full;
    logic [31:0]    skid_data;
    logic [BUS-1:0] skid_pc;

    assign pc_seq   = pc + STEP;
    assign handoff  = if_valid && id_ready;
    assign out_free = !if_valid || id_ready;

    // run holds off the first request until one clock after reset release,
    // so the request pulse only ever depends on registered state.
    assign imem_req  = run && (state == S_REQ);
    assign imem_addr = pc;

    assign skid_load   = (state == S_WAIT) && !branch_taken && imem_valid && !out_free;
    assign skid_unload = (state == S_HOLD) && !branch_taken && id_ready && skid_full;
    assign skid_flush  = (state == S_HOLD) && branch_taken;

    fetch_skid_reg #(
        .BUS (BUS)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skid_load),
        .unload    (skid_unload),
        .flush     (skid_flush),
        .load_data (imem_rdata),
        .load_pc   (pc),
        .full      (skid_full),
        .data      (skid_data),
        .pc        (skid_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_REQ;
            run         <= 1'b0;
            pc          <= RESET_PC;
            if_valid    <= 1'b0;
            if_instr    <= '0;
            if_pc       <= '0;
            fetch_count <= '0;
        end else begin
            run <= 1'b1;

            if (handoff) begin
                fetch_count <= fetch_count + 32'd1;
                if_valid    <= 1'b0;
            end

            case (state)
                S_REQ: begin
                    if (run) begin
                        state <= branch_taken ? S_DROP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (branch_taken) begin
                        state <= imem_valid ? S_REQ : S_DROP;
                    end else if (imem_valid) begin
                        pc <= pc_seq;
                        if (out_free) begin
                            if_instr <= imem_rdata;
                            if_pc    <= pc;
                            if_valid <= 1'b1;
                            state    <= S_REQ;
                        end else begin
                            state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (branch_taken) begin
                        state <= S_REQ;
                    end else if (skid_unload) begin
                        if_instr <= skid_data;
                        if_pc    <= skid_pc;
                        if_valid <= 1'b1;
                        state    <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_valid) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase

            // A redirect overrides any PC advance and flushes the output
            // register, even when the current word was just consumed.
            if (branch_taken) begin
                pc       <= branch_target;
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle table, async reset sequence, then
// randomized memory latency / stalls / redirects against a stream-level model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] fetch_count;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .id_ready      (id_ready),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .fetch_count   (fetch_count)
    );

    // Instruction memory contents as a pure function of address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [31:0] rdata, input logic r,
                         input logic b, input logic [31:0] t);
        imem_valid    = v;
        imem_rdata    = rdata;
        id_ready      = r;
        branch_taken  = b;
        branch_target = t;
    endtask

    task automatic drive_idle();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        valid;
        logic        ready;
        logic        br;
        logic [31:0] tgt;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_ifv;
        logic [31:0] exp_pc;
        logic [31:0] exp_cnt;
    } vec_t;

    localparam int NV = 29;
    vec_t vec[NV];

    function automatic vec_t mk(input logic v, input logic r, input logic b, input logic [31:0] t,
                                input logic q, input logic [31:0] a, input logic iv,
                                input logic [31:0] p, input logic [31:0] c);
        vec_t x;
        x.valid = v; x.ready = r; x.br = b; x.tgt = t;
        x.exp_req = q; x.exp_addr = a; x.exp_ifv = iv; x.exp_pc = p; x.exp_cnt = c;
        return x;
    endfunction

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];   // {pc, instr} words accepted but not yet handed off
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        pending;
    logic        p_drop;
    logic [31:0] p_addr;
    int          lat_cnt;
    int          n_req;

    initial begin
        logic [31:0] last_addr;
        int          cycles;
        logic        v;
        logic        r;
        logic        b;
        logic        req_now;
        logic [31:0] t;
        logic [63:0] head;

        rst_n = 1'b0;
        drive_idle();
        last_addr = 32'h0;

        // zero-wait stream, long stall into skid, redirects, PC wrap
        vec[0]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0, 0);
        vec[1]  = mk(0, 1, 0, 32'h0,        1, 32'h0,        0, 32'h0, 0);
        vec[2]  = mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0, 0);
        vec[3]  = mk(0, 1, 0, 32'h0,        1, 32'h4,        1, 32'h0, 0);
        vec[4]  = mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0, 1);
        vec[5]  = mk(0, 1, 0, 32'h0,        1, 32'h8,        1, 32'h4, 1);
        vec[6]  = mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0, 2);
        vec[7]  = mk(0, 1, 0, 32'h0,        1, 32'hC,        1, 32'h8, 2);
        vec[8]  = mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0, 3);
        vec[9]  = mk(0, 0, 0, 32'h0,        1, 32'h10,       1, 32'hC, 3);
        vec[10] = mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'hC, 3);
        vec[11] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'hC, 3);
        vec[12] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'hC, 3);
        vec[13] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'hC, 3);
        vec[14] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'hC, 3);
        vec[15] = mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'hC, 3);
        vec[16] = mk(0, 1, 0, 32'h0,        1, 32'h14,       1, 32'h10, 4);
        vec[17] = mk(0, 1, 1, 32'h100,      0, 32'h0,        0, 32'h0, 5);
        vec[18] = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0, 5);
        vec[19] = mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0, 5);
        vec[20] = mk(0, 1, 0, 32'h0,        1, 32'h100,      0, 32'h0, 5);
        vec[21] = mk(1, 1, 1, 32'h200,      0, 32'h0,        0, 32'h0, 5);
        vec[22] = mk(0, 1, 1, 32'hFFFF_FFFC, 1, 32'h200,     0, 32'h0, 5);
        vec[23] = mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0, 5);
        vec[24] = mk(0, 1, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h0, 5);
        vec[25] = mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0, 5);
        vec[26] = mk(0, 0, 0, 32'h0,        1, 32'h0,        1, 32'hFFFF_FFFC, 5);
        vec[27] = mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'hFFFF_FFFC, 5);
        vec[28] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'hFFFF_FFFC, 5);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("tbl%0d_req", i), {31'h0, imem_req}, {31'h0, vec[i].exp_req});
            if (vec[i].exp_req) chk($sformatf("tbl%0d_addr", i), imem_addr, vec[i].exp_addr);
            chk($sformatf("tbl%0d_ifv", i), {31'h0, if_valid}, {31'h0, vec[i].exp_ifv});
            if (vec[i].exp_ifv) begin
                chk($sformatf("tbl%0d_pc", i), if_pc, vec[i].exp_pc);
                chk($sformatf("tbl%0d_instr", i), if_instr, mem_word(vec[i].exp_pc));
            end
            chk($sformatf("tbl%0d_cnt", i), fetch_count, vec[i].exp_cnt);
            if (imem_req) last_addr = imem_addr;
            drive(vec[i].valid, mem_word(last_addr), vec[i].ready, vec[i].br, vec[i].tgt);
        end

        // async reset while holding a word in the skid
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_ifv", {31'h0, if_valid}, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_cnt", fetch_count, 32'h0);

        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        cycles = 0;
        while (!imem_req && cycles < 5) begin
            @(negedge clk);
            cycles++;
        end
        chk("first_req_delay", cycles, 1);
        chk("first_req_addr", imem_addr, 32'h0);

        // randomized phase against the stream model
        m_pc    = 32'h0;
        m_cnt   = 32'h0;
        pending = 1'b0;
        p_drop  = 1'b0;
        p_addr  = 32'h0;
        lat_cnt = 0;
        n_req   = 0;
        exp_q.delete();

        for (int c = 0; c < 3000; c++) begin
            if (c > 0) @(negedge clk);
            chk("rnd_ifv", {31'h0, if_valid}, {31'h0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                head = exp_q[0];
                chk("rnd_pc", if_pc, head[63:32]);
                chk("rnd_instr", if_instr, head[31:0]);
            end
            chk("rnd_cnt", fetch_count, m_cnt);

            req_now = imem_req;
            if (req_now) begin
                if (pending) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rnd_overlap: got second request at %h expected none outstanding", imem_addr);
                end
                chk("rnd_addr", imem_addr, m_pc);
                n_req++;
                pending = 1'b1;
                p_drop  = 1'b0;
                p_addr  = imem_addr;
                lat_cnt = $urandom_range(1, 3);
            end

            v = 1'b0;
            if (pending && !req_now) begin
                lat_cnt--;
                if (lat_cnt == 0) v = 1'b1;
            end
            r = ($urandom_range(0, 3) != 0);
            b = ($urandom_range(0, 11) == 0);
            t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            drive(v, mem_word(p_addr), r, b, t);

            // model: handoff first, then redirect flush, then response
            if (exp_q.size() != 0 && r) begin
                void'(exp_q.pop_front());
                m_cnt++;
            end
            if (b && pending) p_drop = 1'b1;
            if (v) begin
                pending = 1'b0;
                if (!p_drop) begin
                    exp_q.push_back({p_addr, mem_word(p_addr)});
                    m_pc = m_pc + 32'd4;
                end
            end
            if (b) begin
                exp_q.delete();
                m_pc = t;
            end
        end

        chk("rnd_progress", {31'h0, n_req >= 300}, 32'h1);

        // ---------------- final report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the instruction decoder.
- Owns the PC register and issues one-outstanding-request reads to instruction memory.
- Holds the fetched word and its PC in an IF/ID output register; these feed the decoder's instruction and PC inputs.
- Handles downstream stall (id_ready low) with a one-entry skid register, and branch redirect with flush plus in-flight response discard.

Parameters:
- BUS, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- PC_STEP, 4, PC increment per accepted instruction.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- imem_req  output  1  one-cycle read request pulse.
- imem_addr  output  BUS  read address; valid when imem_req=1.
- imem_rdata  input  32  returned instruction word.
- imem_valid  input  1  response strobe; arrives at least 1 cycle after imem_req.
- branch_taken  input  1  redirect pulse from branch resolution.
- branch_target  input  BUS  redirect PC; sampled when branch_taken=1.
- id_ready  input  1  downstream accepts if_instr/if_pc this cycle.
- if_valid  output  1  output register holds a live instruction.
- if_instr  output  32  instruction to decoder.
- if_pc  output  BUS  PC of if_instr.
- fetch_count  output  32  number of instructions handed downstream (if_valid & id_ready); wraps at 2^32.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=S_REQ, if_valid=0, if_instr=0, if_pc=0.
  - skid register empty, fetch_count=0.
  - imem_req=0 while in reset.
- State S_REQ:
  - imem_req=1, imem_addr=pc (registered pc only; no combinational path from inputs).
  - Next state S_WAIT.
  - If branch_taken=1 in S_REQ: the request still issues; pc<=branch_target, if_valid<=0, next state S_DROP.
- State S_WAIT:
  - branch_taken=1 has priority:
    - pc<=branch_target, if_valid<=0.
    - If imem_valid=1 the same cycle, the response is discarded and next state is S_REQ; otherwise next state is S_DROP.
  - Else, if imem_valid=1 and output is free (if_valid=0 or id_ready=1): if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+PC_STEP, next S_REQ.
  - Else, if imem_valid=1 and output is stalled: skid<=(imem_rdata, pc), pc<=pc+PC_STEP, next S_HOLD.
- State S_HOLD:
  - No request is issued.
  - When id_ready=1: the output register loads from skid, skid empties, next S_REQ.
  - If branch_taken=1: skid dropped, if_valid<=0, pc<=branch_target, next S_REQ.
- State S_DROP:
  - Waits for imem_valid, discards the word, next S_REQ.
  - branch_taken=1 in S_DROP updates pc and stays in S_DROP until the response arrives.
- Output consumption: if_valid clears on the edge where if_valid=1 and id_ready=1, unless a new word loads that same edge.
- Branch flush beats consumption: when branch_taken=1, if_valid<=0 regardless of id_ready. The current if_instr may still be counted as consumed that cycle if id_ready=1.
- Throughput:
  - Zero-wait memory: one instruction every 2 cycles (S_REQ, S_WAIT).
  - First imem_req occurs the cycle after rst_n deasserts.
- PC arithmetic: modulo 2^BUS; wrap from 32'hFFFF_FFFC to 0 without flag.
- Never more than one outstanding memory request.
- Reset mid-request: state is abandoned. The memory side must also be reset, or a late imem_valid must arrive while the FSM is in S_REQ; in S_REQ any such imem_valid is ignored.

Decomposition:
- Shared package (e.g. cpu_pkg):
  - fetch state enum {S_REQ, S_WAIT, S_HOLD, S_DROP}.
  - BUS default.
  - RESET_PC.
  - Instruction-field constants: FUNTYPE [31:30], FUNCODE [29:28], RD [27:24].
- Sub-module: fetch_skid_reg, holding the one-entry skid (data, pc, full) with load/unload/flush.
- FSM and PC logic stay in fetch_stage.

Test Plan:
- Release reset, memory returns 1 cycle after each req, id_ready=1 -> imem_addr sequence 0,4,8,12; if_pc matches; fetch_count=4 after 4 handoffs; if_valid pulses every 2nd cycle.
- Fetch at 0, hold id_ready=0 for 6 cycles while second word (addr 4) returns:
  - Second word goes to skid, state S_HOLD, no imem_req.
  - On id_ready=1, if_pc=0 is consumed, then if_pc=4 is presented.
  - Next imem_addr=8.
- branch_taken with target 32'h100 in S_WAIT, imem_valid arrives 2 cycles later -> response dropped (S_DROP), if_valid=0, next imem_addr=32'h100.
- branch_taken and imem_valid same cycle -> word discarded, if_valid=0, next request at branch_target the following cycle.
- Assert rst_n=0 while in S_HOLD with if_valid=1 -> all outputs zero immediately (asynchronously), pc=RESET_PC, fetch_count=0, first req after release at RESET_PC.
- PC at 32'hFFFF_FFFC with an accepted response -> next imem_addr=0.
